// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter.
// Contents: transmitter state type, default bit period, frame length in bit periods.
package uart_pkg;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 80;

   // start + 8 data + stop
   localparam int unsigned FRAME_BITS = 10;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: loads a byte in idle and shifts it out LSB first.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   load        - accept tx_byte this cycle (honoured only when idle)
//   tx_byte     - byte to send
//   txd         - registered serial line, idle high
//   busy        - a frame is in progress
//   done        - high in the last cycle of the stop bit
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] tx_byte,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

   tx_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            txd_q, txd_d;
   logic            bit_end;

   assign bit_end = (cnt_q == CntLast);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   // The line value for the next bit is computed one cycle early so txd
   // comes straight from a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      unique case (state_q)
         StIdle: begin
            txd_d = 1'b1;
            if (load) begin
               state_d = StStart;
               cnt_d   = '0;
               idx_d   = '0;
               shift_d = tx_byte;
               txd_d   = 1'b0;
            end
         end
         StStart: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = StData;
               txd_d   = shift_q[0];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  state_d = StStop;
                  txd_d   = 1'b1;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = StIdle;
               txd_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q != StIdle);
      done = (state_q == StStop) && bit_end;
   end

   assign txd = txd_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a single UART transmitter.
// Ports:
//   clk, reset              - rising-edge clock, synchronous active-high reset
//   req0_valid/data/ready   - requester 0 (CPU) byte handshake
//   req1_valid/data/ready   - requester 1 (aux/debug) byte handshake
//   ser_txd                 - serial line, idle high
//   busy                    - frame in progress
//   grant_id                - owner of the current or most recent frame
//   frame_done              - one-cycle pulse in the last stop-bit cycle
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       ser_txd,
   output logic       busy,
   output logic       grant_id,
   output logic       frame_done
);

   // last_q = 1 means requester 1 won the previous handshake; reset value
   // makes requester 0 win the first tie.
   logic       last_q;
   logic       grant_id_q;
   logic       gnt0, gnt1, load;
   logic [7:0] load_byte;
   logic       core_busy, core_done;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset && !core_busy) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_q;
            gnt1 = !last_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign load      = gnt0 | gnt1;
   assign load_byte = gnt1 ? req1_data : req0_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q     <= 1'b1;
         grant_id_q <= 1'b0;
      end else if (load) begin
         last_q     <= gnt1;
         grant_id_q <= gnt1;
      end
   end

   uart_tx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .tx_byte(load_byte),
      .txd    (ser_txd),
      .busy   (core_busy),
      .done   (core_done)
   );

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign busy       = core_busy;
   assign grant_id   = grant_id_q;
   // Suppress a stop-bit pulse that coincides with reset.
   assign frame_done = core_done & ~reset;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int unsigned Cpb   = 80;
   localparam int          Frame = FRAME_BITS * Cpb;

   logic       clk;
   logic       reset, r0v, r0r, r1v, r1r, txd, busy, gid, fd;
   logic [7:0] r0d, r1d;
   logic       reset_b, r0v_b, r0r_b, r1v_b, r1r_b, txd_b, busy_b, gid_b, fd_b;
   logic [7:0] r0d_b, r1d_b;

   int         n_chk = 0;
   int         n_bad = 0;
   logic [7:0] rxq[$];

   uart_tx_arbiter #(.CLKS_PER_BIT(Cpb)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
      .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
      .ser_txd(txd), .busy(busy), .grant_id(gid), .frame_done(fd)
   );

   uart_tx_arbiter #(.CLKS_PER_BIT(2)) dut_b (
      .clk(clk), .reset(reset_b),
      .req0_valid(r0v_b), .req0_data(r0d_b), .req0_ready(r0r_b),
      .req1_valid(r1v_b), .req1_data(r1d_b), .req1_ready(r1r_b),
      .ser_txd(txd_b), .busy(busy_b), .grant_id(gid_b), .frame_done(fd_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at the sample point of a handshake cycle; new input values are
   // applied in the first cycle after the handshake.
   task automatic frame(input logic [7:0] eb, input logic eg, input logic nv0, input logic nv1,
                        input logic [7:0] nd0, input logic [7:0] nd1);
      int         fd_cnt;
      int         fd_at;
      logic [7:0] rx;
      fd_cnt = 0;
      fd_at  = 0;
      rx     = '0;
      for (int k = 1; k <= Frame; k++) begin
         @(negedge clk);
         if (k == 1) begin
            r0v = nv0; r1v = nv1; r0d = nd0; r1d = nd1;
         end
         #1;
         if (fd) begin
            fd_cnt++;
            fd_at = k;
         end
         if (k == 1) begin
            chk("start_first", txd, 0);
            chk("busy_in_frame", busy, 1);
            chk("grant_id", gid, eg);
            chk("rdy_while_busy", {r0r, r1r}, 0);
         end
         if (k == Cpb) chk("start_last", txd, 0);
         if (k == Cpb + 1) chk("bit0_first", txd, eb[0]);
         if (k > Cpb && k <= 9 * Cpb && (k % Cpb) == Cpb / 2) rx[(k / Cpb) - 1] = txd;
         if (k == 9 * Cpb + Cpb / 2) chk("stop_bit", txd, 1);
         if (k == Frame) chk("rdy_at_done", {r0r, r1r}, 0);
      end
      chk("fd_count", fd_cnt, 1);
      chk("fd_at", fd_at, Frame);
      chk("rx_byte", rx, eb);
      rxq.push_back(rx);
   endtask

   task automatic wait_hs(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (r0r | r1r) ok = 1'b1;
         else begin
            @(negedge clk);
            #1;
         end
      end
      chk("hs_timeout", ok, 1);
   endtask

   initial begin
      logic       ok;
      int         idle_bad, idle_fd, ab_fd, b_fd, b_fd_at;
      logic [7:0] d0[3];
      logic [7:0] d1[3];
      logic [7:0] exp_q[4];
      int         i0, i1;
      logic       eid;
      logic [7:0] eb;

      reset = 1'b1; r0v = 1'b1; r1v = 1'b1; r0d = 8'h00; r1d = 8'h00;
      reset_b = 1'b1; r0v_b = 1'b0; r1v_b = 1'b0; r0d_b = 8'h00; r1d_b = 8'h00;

      // Reset state, with both requesters valid
      repeat (3) @(negedge clk);
      #1;
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_fd", fd, 0);
      chk("rst_gid", gid, 0);
      chk("rst_rdy", {r0r, r1r}, 0);
      @(negedge clk);
      r0v = 1'b0; r1v = 1'b0; reset = 1'b0;

      // Idle for 1000 cycles
      idle_bad = 0;
      idle_fd  = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         #1;
         if (txd !== 1'b1 || busy !== 1'b0 || r0r !== 1'b0 || r1r !== 1'b0) idle_bad++;
         if (fd) idle_fd++;
      end
      chk("idle_bad", idle_bad, 0);
      chk("idle_fd", idle_fd, 0);

      // Single request 0xA5 from req0
      @(negedge clk);
      r0v = 1'b1; r0d = 8'hA5;
      #1;
      wait_hs(ok);
      chk("single_rdy0", r0r, 1);
      chk("single_rdy1", r1r, 0);
      frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      // Tie straight after reset
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      r0v = 1'b1; r0d = 8'h11; r1v = 1'b1; r1d = 8'h22;
      #1;
      chk("tie_rdy0", r0r, 1);
      chk("tie_rdy1", r1r, 0);
      rxq.delete();
      frame(8'h11, 1'b0, 1'b0, 1'b1, 8'h00, 8'h22);
      @(negedge clk);
      #1;
      chk("tie_rdy1_after_done", r1r, 1);
      frame(8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("tie_order0", rxq[0], 8'h11);
      chk("tie_order1", rxq[1], 8'h22);

      // Continuous contention over four frames
      d0 = '{8'h30, 8'h31, 8'h32};
      d1 = '{8'h40, 8'h41, 8'h42};
      exp_q = '{8'h30, 8'h40, 8'h31, 8'h41};
      i0 = 0;
      i1 = 0;
      rxq.delete();
      @(negedge clk);
      r0v = 1'b1; r1v = 1'b1; r0d = d0[0]; r1d = d1[0];
      #1;
      for (int f = 0; f < 4; f++) begin
         if (f > 0) begin
            @(negedge clk);
            #1;
         end
         wait_hs(ok);
         eid = (f % 2) == 1;
         chk("cont_rdy1", r1r, eid);
         chk("cont_rdy0", r0r, !eid);
         if (eid) begin
            eb = d1[i1];
            i1++;
         end else begin
            eb = d0[i0];
            i0++;
         end
         frame(eb, eid, 1'b1, 1'b1, d0[i0], d1[i1]);
      end
      @(negedge clk);
      r0v = 1'b0; r1v = 1'b0;
      chk("cont_qlen", rxq.size(), 4);
      for (int i = 0; i < 4; i++) chk("cont_order", rxq[i], exp_q[i]);

      // Reset during data bit 3 of a req0 frame (pointer would favour req1)
      @(negedge clk);
      r0v = 1'b1; r0d = 8'h52;
      #1;
      wait_hs(ok);
      chk("ab_rdy0", r0r, 1);
      ab_fd = 0;
      for (int k = 1; k <= 4 * Cpb + 10; k++) begin
         @(negedge clk);
         if (k == 1) r0v = 1'b0;
         #1;
         if (fd) ab_fd++;
      end
      chk("ab_bit3", txd, 0);
      reset = 1'b1;
      r0v = 1'b1; r0d = 8'h77; r1v = 1'b1; r1d = 8'h88;
      @(negedge clk);
      #1;
      chk("ab_txd", txd, 1);
      chk("ab_busy", busy, 0);
      chk("ab_fd", fd, 0);
      chk("ab_rdy_in_reset", {r0r, r1r}, 0);
      chk("ab_fd_count", ab_fd, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ab_tie_rdy0", r0r, 1);
      chk("ab_tie_rdy1", r1r, 0);
      frame(8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      // CLKS_PER_BIT = 2, req1 sends 0xFF
      @(negedge clk);
      reset_b = 1'b0;
      @(negedge clk);
      r1v_b = 1'b1; r1d_b = 8'hFF;
      #1;
      chk("b_rdy1", r1r_b, 1);
      chk("b_rdy0", r0r_b, 0);
      b_fd    = 0;
      b_fd_at = 0;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         if (k == 1) r1v_b = 1'b0;
         #1;
         if (fd_b) begin
            b_fd++;
            b_fd_at = k;
         end
         if (k == 1) chk("b_start1", txd_b, 0);
         if (k == 2) chk("b_start2", txd_b, 0);
         if (k == 3) chk("b_bit0", txd_b, 1);
         if (k == 18) chk("b_bit7", txd_b, 1);
         if (k == 20) chk("b_busy_last", busy_b, 1);
         if (k == 21) chk("b_idle_after", busy_b, 0);
      end
      chk("b_fd_count", b_fd, 1);
      chk("b_fd_at", b_fd_at, 20);
      chk("b_gid", gid_b, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
